// File: rtl/dm_hart_status_fsm.sv
// Debug-module side of the hart run-control handshake for a single hart.
// Drives GO/RESUME flags and reports abstract-command status and errors.
module dm_hart_status_fsm #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_halted_en_i,
  input  logic       wr_going_en_i,
  input  logic       wr_resuming_en_i,
  input  logic       wr_exception_en_i,
  input  logic       clear_resumeack_i,
  input  logic       cmd_valid_i,
  input  logic       resumereq_i,
  output logic       halted_o,
  output logic       resumeack_o,
  output logic       cmdbusy_o,
  output logic       go_o,
  output logic       resume_o,
  output logic       cmderror_valid_o,
  output logic [2:0] cmderror_o
);

  localparam int unsigned CntW =
    (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam bit TmoEn = (TimeoutCycles != 0);
  localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] TmoMax  = CntW'(TimeoutCycles);

  localparam logic [2:0] ErrException  = 3'd3;
  localparam logic [2:0] ErrHaltResume = 3'd4;
  localparam logic [2:0] ErrOther      = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    GO,
    EXEC,
    RESUME
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            halted_q, halted_d;
  logic            rack_q, rack_d;
  logic            errv_q, errv_d;
  logic [2:0]      err_q, err_d;
  logic            rack_clr;
  logic            tmo;
  logic            busy;

  assign busy = (state_q == GO) || (state_q == EXEC);
  assign tmo  = TmoEn && (cnt_q == TmoLast);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    errv_d   = 1'b0;
    err_d    = err_q;
    rack_clr = clear_resumeack_i;

    if (busy && TmoEn && (cnt_q != TmoMax)) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (halted_q) begin
            state_d = GO;
            cnt_d   = '0;
          end else begin
            errv_d = 1'b1;
            err_d  = ErrHaltResume;
          end
        end else if (resumereq_i && halted_q) begin
          state_d  = RESUME;
          rack_clr = 1'b1;
        end
      end
      // A timeout beats a late going strobe so the command cannot hang.
      GO: begin
        if (tmo) begin
          state_d = IDLE;
          errv_d  = 1'b1;
          err_d   = ErrOther;
        end else if (wr_going_en_i) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (wr_exception_en_i) begin
          state_d = IDLE;
          errv_d  = 1'b1;
          err_d   = ErrException;
        end else if (wr_halted_en_i) begin
          state_d = IDLE;
        end else if (tmo) begin
          state_d = IDLE;
          errv_d  = 1'b1;
          err_d   = ErrOther;
        end
      end
      RESUME: begin
        if (wr_resuming_en_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    halted_d = wr_halted_en_i ? 1'b1 :
               wr_resuming_en_i ? 1'b0 : halted_q;
    rack_d   = wr_resuming_en_i ? 1'b1 :
               rack_clr ? 1'b0 : rack_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      rack_q   <= 1'b0;
      errv_q   <= 1'b0;
      err_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      rack_q   <= rack_d;
      errv_q   <= errv_d;
      err_q    <= err_d;
    end
  end

  assign halted_o         = halted_q;
  assign resumeack_o      = rack_q;
  assign cmdbusy_o        = busy;
  assign go_o             = (state_q == GO);
  assign resume_o         = (state_q == RESUME);
  assign cmderror_valid_o = errv_q;
  assign cmderror_o       = err_q;

endmodule

// File: tb/tb_dm_hart_status_fsm.sv
// Scoreboard bench for dm_hart_status_fsm with an 8-cycle timeout.
// Outputs packed as {halted,rack,busy,go,resume,errv,err[2:0]}.
module tb_dm_hart_status_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_h = 1'b0, wr_g = 1'b0, wr_r = 1'b0, wr_e = 1'b0;
  logic       clr = 1'b0, cmd = 1'b0, rreq = 1'b0;
  logic       halted, rack, busy, go, res, errv;
  logic [2:0] err;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    string      tag;
    logic [8:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  dm_hart_status_fsm #(.TimeoutCycles(8)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .wr_halted_en_i   (wr_h),
    .wr_going_en_i    (wr_g),
    .wr_resuming_en_i (wr_r),
    .wr_exception_en_i(wr_e),
    .clear_resumeack_i(clr),
    .cmd_valid_i      (cmd),
    .resumereq_i      (rreq),
    .halted_o         (halted),
    .resumeack_o      (rack),
    .cmdbusy_o        (busy),
    .go_o             (go),
    .resume_o         (res),
    .cmderror_valid_o (errv),
    .cmderror_o       (err)
  );

  function automatic logic [8:0] obs();
    return {halted, rack, busy, go, res, errv, err};
  endfunction

  function automatic logic [8:0] e(
    input logic h, input logic a, input logic b,
    input logic g, input logic r, input logic v,
    input logic [2:0] c);
    return {h, a, b, g, r, v, c};
  endfunction

  task automatic chk(input string tag,
                     input logic [8:0] got,
                     input logic [8:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%b want=%b", tag, got, want);
    end
  endtask

  // stim bits: {wr_h,wr_g,wr_r,wr_e,clr,cmd,rreq}
  task automatic cyc(input string tag, input logic [6:0] s,
                     input logic [8:0] want);
    exp_t x;
    {wr_h, wr_g, wr_r, wr_e, clr, cmd, rreq} = s;
    sb.push_back('{tag, want});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk(x.tag, obs(), x.val);
  endtask

  localparam logic [6:0] N  = 7'b0000000;
  localparam logic [6:0] H  = 7'b1000000;
  localparam logic [6:0] G  = 7'b0100000;
  localparam logic [6:0] R  = 7'b0010000;
  localparam logic [6:0] X  = 7'b0001000;
  localparam logic [6:0] C  = 7'b0000100;
  localparam logic [6:0] V  = 7'b0000010;
  localparam logic [6:0] Q  = 7'b0000001;

  initial begin
    #2 rst_n = 1'b0;
    #1 chk("reset", obs(), 9'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_rel", obs(), 9'd0);

    cyc("t1_halt",  H, e(1,0,0,0,0,0,0));
    cyc("t1_cmd",   V, e(1,0,1,1,0,0,0));
    cyc("t1_go2",   N, e(1,0,1,1,0,0,0));
    cyc("t1_going", G, e(1,0,1,0,0,0,0));
    cyc("t1_exec1", N, e(1,0,1,0,0,0,0));
    cyc("t1_exec2", N, e(1,0,1,0,0,0,0));
    cyc("t1_done",  H, e(1,0,0,0,0,0,0));
    cyc("t1_nopls", N, e(1,0,0,0,0,0,0));

    cyc("t3_rreq",  Q, e(1,0,0,0,1,0,0));
    cyc("t3_wait",  Q, e(1,0,0,0,1,0,0));
    cyc("t3_rsm",   R | Q, e(0,1,0,0,0,0,0));
    cyc("t3_idle",  N, e(0,1,0,0,0,0,0));
    cyc("t3_clr",   C, e(0,0,0,0,0,0,0));

    cyc("t2_cmd",   V, e(0,0,0,0,0,1,3'd4));
    cyc("t2_hold",  N, e(0,0,0,0,0,0,3'd4));

    cyc("t4_halt",  H, e(1,0,0,0,0,0,3'd4));
    cyc("t4_cmd",   V, e(1,0,1,1,0,0,3'd4));
    for (int i = 0; i < 7; i++) begin
      cyc("t4_busy", N, e(1,0,1,1,0,0,3'd4));
    end
    cyc("t4_tmo",   N, e(1,0,0,0,0,1,3'd7));
    cyc("t4_hold",  N, e(1,0,0,0,0,0,3'd7));
    cyc("t4_cmd2",  V, e(1,0,1,1,0,0,3'd7));
    cyc("t4_going", G, e(1,0,1,0,0,0,3'd7));
    cyc("t4_exc",   X | H, e(1,0,0,0,0,1,3'd3));
    cyc("t4_hold2", N, e(1,0,0,0,0,0,3'd3));

    cyc("t5_both",  V | Q, e(1,0,1,1,0,0,3'd3));
    cyc("t5_going", G | Q, e(1,0,1,0,0,0,3'd3));
    cyc("t5_done",  H | Q, e(1,0,0,0,0,0,3'd3));
    cyc("t5_rsm",   Q, e(1,0,0,0,1,0,3'd3));
    cyc("t5_ack",   R | Q, e(0,1,0,0,0,0,3'd3));
    cyc("t5_idle",  N, e(0,1,0,0,0,0,3'd3));

    cyc("hs_setwin", H | R, e(1,1,0,0,0,0,3'd3));
    cyc("ra_setwin", R | C, e(0,1,0,0,0,0,3'd3));
    cyc("ra_clr",    C, e(0,0,0,0,0,0,3'd3));

    cyc("t6_halt",  H, e(1,0,0,0,0,0,3'd3));
    cyc("t6_cmd",   V, e(1,0,1,1,0,0,3'd3));
    cyc("t6_going", G, e(1,0,1,0,0,0,3'd3));
    {wr_h, wr_g, wr_r, wr_e, clr, cmd, rreq} = N;
    #2 rst_n = 1'b0;
    #1 chk("t6_async", obs(), 9'd0);
    @(posedge clk);
    #1 chk("t6_held", obs(), 9'd0);
    rst_n = 1'b1;
    cyc("t6_idle",  N, e(0,0,0,0,0,0,0));
    cyc("t6_cmd4",  V, e(0,0,0,0,0,1,3'd4));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
